// File: rtl/niosII_timer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// niosII_timer_pkg : register map, CONTROL bit indices, clog2 helper
// rev 1.0
// ------------------------------------------------------------------
package niosII_timer_pkg;

   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_CONTROL = 2'd1;
   localparam logic [1:0] REG_PERIOD  = 2'd2;
   localparam logic [1:0] REG_SNAP    = 2'd3;

   localparam int IE    = 0;
   localparam int CONT  = 1;
   localparam int START = 2;
   localparam int STOP  = 3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/niosii_multi_timer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// niosii_multi_timer_if : Avalon-MM slave bus plus interrupt outputs
// rev 1.0
// ------------------------------------------------------------------
interface niosii_multi_timer_if #(
   parameter int NCH = 4
);
   import niosII_timer_pkg::*;

   localparam int AW = clog2(NCH) + 2;

   logic [AW-1:0]  address;
   logic           chipselect;
   logic           write_n;
   logic [31:0]    writedata;
   logic [31:0]    readdata;
   logic           irq;
   logic [NCH-1:0] irq_vec;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq, irq_vec
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq, irq_vec
   );

endinterface
`default_nettype wire

// File: rtl/niosII_timer_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// niosII_timer_channel : one down-counter with period, snap, run/to
// rev 1.0
// ------------------------------------------------------------------
module niosII_timer_channel
   import niosII_timer_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'd99999
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             wr_status,
   input  wire logic             wr_control,
   input  wire logic             wr_period,
   input  wire logic             wr_snap,
   input  wire logic [3:0]       ctrl,
   input  wire logic [WIDTH-1:0] period_in,
   output logic      [WIDTH-1:0] period,
   output logic      [WIDTH-1:0] snap,
   output logic                  run,
   output logic                  to,
   output logic                  cont,
   output logic                  ie
);

   localparam logic [WIDTH-1:0] C_RESET = WIDTH'(RESET_PERIOD);

   logic [WIDTH-1:0] r_count;
   logic             r_evt_q;
   logic             w_start;
   logic             w_stop;
   logic             w_hit;
   logic             w_event;

   assign w_stop  = wr_control & ctrl[STOP];
   assign w_start = wr_control & ctrl[START] & ~ctrl[STOP];
   assign w_hit   = run & (r_count == '0);
   // Masking on the previous event makes a zero period fire every other cycle;
   // a start pulse reloads a zero counter without counting it as a timeout.
   assign w_event = w_hit & ~r_evt_q & ~w_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= C_RESET;
         period  <= C_RESET;
         snap    <= '0;
         run     <= 1'b0;
         to      <= 1'b0;
         cont    <= 1'b0;
         ie      <= 1'b0;
         r_evt_q <= 1'b0;
      end else begin
         r_evt_q <= w_event;

         if (wr_period) begin
            period  <= period_in;
            r_count <= period_in;
         end else if ((w_start || run) && (r_count == '0)) begin
            r_count <= period;
         end else if (run) begin
            r_count <= r_count - WIDTH'(1);
         end

         if (w_stop)                run <= 1'b0;
         else if (w_start)          run <= 1'b1;
         else if (w_hit && !cont)   run <= 1'b0;

         if (wr_control) begin
            cont <= ctrl[CONT];
            ie   <= ctrl[IE];
         end

         if (w_event)        to <= 1'b1;
         else if (wr_status) to <= 1'b0;

         if (wr_snap) snap <= r_count;
      end
   end

endmodule
`default_nettype wire

// File: rtl/niosii_multi_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// niosii_multi_timer : NCH-channel interval timer, decode/read mux/IRQ
// rev 1.0
// ------------------------------------------------------------------
module niosii_multi_timer
   import niosII_timer_pkg::*;
#(
   parameter int          NCH          = 4,
   parameter int          WIDTH        = 32,
   parameter logic [31:0] RESET_PERIOD = 32'd99999
) (
   input wire logic                 clk,
   input wire logic                 reset,
   niosii_multi_timer_if.slave      bus
);

   localparam int AW = clog2(NCH) + 2;
   localparam int CW = (AW > 2) ? AW - 2 : 1;

   logic [CW-1:0]                w_ch;
   logic [1:0]                   w_reg;
   logic                         w_wr;
   logic [31:0]                  w_rdata;
   logic [NCH-1:0]               w_run;
   logic [NCH-1:0]               w_to;
   logic [NCH-1:0]               w_cont;
   logic [NCH-1:0]               w_ie;
   logic [NCH-1:0][WIDTH-1:0]    w_period;
   logic [NCH-1:0][WIDTH-1:0]    w_snap;
   logic [NCH-1:0][31:0]         w_word;

   assign w_reg = bus.address[1:0];
   assign w_wr  = bus.chipselect & ~bus.write_n;

   generate
      if (AW > 2) begin : g_chsel
         assign w_ch = bus.address[AW-1:2];
      end else begin : g_chsel_single
         assign w_ch = 1'b0;
      end

      if (WIDTH < 32) begin : g_unused_hi
         logic w_unused_hi;
         assign w_unused_hi = ^bus.writedata[31:WIDTH];
      end
   endgenerate

   // Channel indices with no instance never match a select, so they read 0
   // and swallow writes.
   generate
      for (genvar i = 0; i < NCH; i++) begin : g_ch
         logic w_sel;
         assign w_sel = w_wr & (w_ch == CW'(i));

         niosII_timer_channel #(
            .WIDTH        (WIDTH),
            .RESET_PERIOD (RESET_PERIOD)
         ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_status  (w_sel & (w_reg == REG_STATUS)),
            .wr_control (w_sel & (w_reg == REG_CONTROL)),
            .wr_period  (w_sel & (w_reg == REG_PERIOD)),
            .wr_snap    (w_sel & (w_reg == REG_SNAP)),
            .ctrl       (bus.writedata[3:0]),
            .period_in  (bus.writedata[WIDTH-1:0]),
            .period     (w_period[i]),
            .snap       (w_snap[i]),
            .run        (w_run[i]),
            .to         (w_to[i]),
            .cont       (w_cont[i]),
            .ie         (w_ie[i])
         );

         assign w_word[i] = (w_reg == REG_STATUS)  ? {30'b0, w_run[i], w_to[i]} :
                            (w_reg == REG_CONTROL) ? {30'b0, w_cont[i], w_ie[i]} :
                            (w_reg == REG_PERIOD)  ? 32'(w_period[i]) :
                                                     32'(w_snap[i]);
      end
   endgenerate

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_ch == CW'(i)) w_rdata = w_word[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= w_rdata;
   end

   assign bus.irq_vec = w_to & w_ie;
   assign bus.irq     = |(w_to & w_ie);

endmodule
`default_nettype wire

// File: doc/niosii_multi_timer.md
Name: niosII_multi_timer

Overview:
- Parametrised, multi-channel Avalon-MM interval timer; next generation of the system clock timer.
- NCH independent down-counters of WIDTH bits. Each channel has a writable period, one-shot or continuous mode, a snapshot register and a sticky timeout flag.
- The per-channel IRQ enables are ORed into one irq to the Nios II CPU. A per-channel irq_vec is also exported for the vectored interrupt controller.

Parameters:
- NCH, 4: number of timer channels, 1..8.
- WIDTH, 32: counter/period width, 8..32.
- RESET_PERIOD, 32'd99999: period loaded into every channel at reset (1 ms at 100 MHz).

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- address  in  clog2(NCH)+2: word address; upper bits select the channel, low 2 bits select the register.
- chipselect  in  1: slave select.
- write_n  in  1: active-low write strobe.
- writedata  in  32: write data.
- readdata  out  32: registered read data.
- irq  out  1: OR of irq_vec.
- irq_vec  out  NCH: per-channel interrupt (timeout AND ie).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state changes only on the rising edge of clk.
- Register map per channel, selected by address[1:0]:
  - 0 STATUS: read {30'b0, run, to}. Any write clears `to`.
  - 1 CONTROL: bits [3:0] = {stop, start, cont, ie}. cont and ie are stored; start and stop are write-only pulses. Reads return {28'b0, 1'b0, 1'b0, cont, ie}.
  - 2 PERIOD: RW. Only [WIDTH-1:0] are stored; upper bits are written as don't-care and read as 0.
  - 3 SNAP: a write captures the live counter into snap. Reads return the zero-extended snap.
- Channels with index >= NCH, reachable only when NCH is not a power of 2: reads return 0, writes are ignored.
- Reset values: readdata=0, irq=0, irq_vec=0. Per channel: counter=RESET_PERIOD, period=RESET_PERIOD, snap=0, run=0, to=0, cont=0, ie=0.
- Read latency: readdata is registered and valid exactly 1 cycle after the address is presented. It is updated every cycle from the current address, whether or not chipselect is asserted. No wait states.
- Counter, while run=1:
  - counter!=0: counter decrements by 1.
  - counter==0: counter reloads period. If cont=0, run clears in the same cycle.
  - The count sequence is period, period-1, ..., 0, so one timeout occurs every period+1 cycles.
- Counter while run=0: holds its value.
- Timeout event: the first cycle in which counter==0 while run=1. Edge-detected, so a held zero does not retrigger.
- Sticky flag: a timeout event sets `to`. On the same cycle as a STATUS write, set wins over clear, so no event is lost.
- Start/stop: start sets run, stop clears run. If both bits are written in one access, stop wins.
- PERIOD write:
  - Stores the new period.
  - Force-reloads the counter with the new value on the next cycle.
  - Leaves run unchanged. This is a deliberate change from the previous generation, which stopped the counter.
- Period of 0: with cont=1 the channel times out on every cycle the counter is 0. The edge detector then fires once per 2 cycles. Define and verify this case; it is not an error.
- Start with counter==0 (one-shot finished): the next cycle reloads the period and raises no timeout. run stays 1 because the start pulse has priority over the one-shot stop.
- Interrupts: irq_vec[i] = to[i] & ie[i] is combinational from registered state. irq = |irq_vec.
- Reset mid-count: all state returns to its reset values on the next edge, and pending flags are lost.

Decomposition:
- Package niosII_timer_pkg holds:
  - register-offset localparams: REG_STATUS=0, REG_CONTROL=1, REG_PERIOD=2, REG_SNAP=3;
  - CONTROL bit-index constants: IE=0, CONT=1, START=2, STOP=3;
  - a function returning clog2(NCH).
- One sub-module, niosII_timer_channel, is instantiated NCH times via generate. It holds the counter, period, snap, run, to, cont, ie and the edge detector.
- The top level contains address decode, the registered read mux and the IRQ OR.

Test Plan:
- Reset, then read each STATUS/PERIOD of channels 0..3 → STATUS=0 and PERIOD=99999, with data appearing 1 cycle after the address.
- Ch1: PERIOD=9, CONTROL=0b0111 (start, cont, ie) → to rises every 10 cycles, irq_vec=4'b0010 and irq=1. Write STATUS → irq drops next cycle. Ch0/2/3 counters stay static.
- Ch2 one-shot: PERIOD=4, CONTROL=0b0101 → exactly one timeout after 5 cycles, then run=0 and the counter holds 4. A second start produces one further timeout.
- Ch0: PERIOD=100, start cont, wait 30 cycles, write SNAP, read SNAP → 70 (±1 per the defined write-cycle alignment). Write PERIOD=20 mid-count → reload to 20 next cycle with run still 1.
- Collisions: a STATUS write on the same cycle as a timeout event → to reads 1. CONTROL=0b1100 → run=0.
- Edge cases: NCH=3, WIDTH=8 build. Access to channel 3 reads 0 and writes have no effect. PERIOD=255 wraps cleanly. PERIOD=0 with cont → timeout every 2 cycles.
